// File: rtl/udp_cmd_rx.sv
`default_nettype none
// =============================================================================
// udp_cmd_rx : GMII frame receiver that validates Ethernet/IPv4/UDP headers and
//              the FCS, then issues one command word from the UDP payload.
// Revision   : 1.0
// =============================================================================
module udp_cmd_rx #(
  parameter logic [47:0] LOCAL_MAC = 48'h000A35000001,
  parameter logic [15:0] CMD_PORT  = 16'h1234
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rx_data,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic [31:0] cmd_arg,
  output logic [15:0] frame_ok_cnt,
  output logic [15:0] frame_err_cnt,
  output logic        busy
);

  localparam logic [31:0] c_crc_poly    = 32'hEDB88320;
  localparam logic [31:0] c_crc_init    = 32'hFFFFFFFF;
  localparam logic [31:0] c_crc_residue = 32'hDEBB20E3;
  localparam logic [10:0] c_min_len     = 11'd64;
  localparam logic [10:0] c_max_len     = 11'd1522;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    FRAME    = 3'd2,
    CHECK    = 3'd3,
    DROP     = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        dv_prev_q, dv_prev_d;
  logic [2:0]  pre_cnt_q, pre_cnt_d;
  logic [10:0] idx_q, idx_d;
  logic [31:0] crc_q, crc_d;
  logic        er_q, er_d;
  logic        ucast_q, ucast_d;
  logic        bcast_q, bcast_d;
  logic        type_q, type_d;
  logic        ver_q, ver_d;
  logic        proto_q, proto_d;
  logic        port_q, port_d;
  logic [7:0]  code_sh_q, code_sh_d;
  logic [31:0] arg_sh_q, arg_sh_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  cmd_code_q, cmd_code_d;
  logic [31:0] cmd_arg_q, cmd_arg_d;
  logic [15:0] frame_ok_cnt_q, frame_ok_cnt_d;
  logic [15:0] frame_err_cnt_q, frame_err_cnt_d;

  logic [7:0]  mac_byte;
  logic        frame_err;
  logic        hdr_match;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ c_crc_poly) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    mac_byte = LOCAL_MAC[7:0];
    case (idx_q[2:0])
      3'd0:    mac_byte = LOCAL_MAC[47:40];
      3'd1:    mac_byte = LOCAL_MAC[39:32];
      3'd2:    mac_byte = LOCAL_MAC[31:24];
      3'd3:    mac_byte = LOCAL_MAC[23:16];
      3'd4:    mac_byte = LOCAL_MAC[15:8];
      default: mac_byte = LOCAL_MAC[7:0];
    endcase
  end

  // idx_q holds the number of frame bytes seen once rx_dv has dropped
  assign frame_err = er_q || (crc_q != c_crc_residue) || (idx_q < c_min_len) || (idx_q > c_max_len);
  assign hdr_match = (ucast_q || bcast_q) && type_q && ver_q && proto_q && port_q;

  always_comb begin
    state_d         = state_q;
    dv_prev_d       = rx_dv;
    pre_cnt_d       = pre_cnt_q;
    idx_d           = idx_q;
    crc_d           = crc_q;
    er_d            = er_q;
    ucast_d         = ucast_q;
    bcast_d         = bcast_q;
    type_d          = type_q;
    ver_d           = ver_q;
    proto_d         = proto_q;
    port_d          = port_q;
    code_sh_d       = code_sh_q;
    arg_sh_d        = arg_sh_q;
    cmd_valid_d     = 1'b0;
    cmd_code_d      = cmd_code_q;
    cmd_arg_d       = cmd_arg_q;
    frame_ok_cnt_d  = frame_ok_cnt_q;
    frame_err_cnt_d = frame_err_cnt_q;

    case (state_q)
      IDLE: begin
        if (rx_dv && !dv_prev_q) begin
          if (rx_data == 8'h55) begin
            state_d   = PREAMBLE;
            pre_cnt_d = 3'd1;
          end else begin
            state_d = DROP;
          end
        end
      end
      PREAMBLE: begin
        if (!rx_dv) begin
          state_d = IDLE;
        end else if (rx_data == 8'hD5) begin
          state_d = FRAME;
          idx_d   = '0;
          crc_d   = c_crc_init;
          er_d    = 1'b0;
          ucast_d = 1'b1;
          bcast_d = 1'b1;
          type_d  = 1'b1;
          ver_d   = 1'b1;
          proto_d = 1'b1;
          port_d  = 1'b1;
        end else if ((rx_data == 8'h55) && (pre_cnt_q != 3'd7)) begin
          pre_cnt_d = pre_cnt_q + 3'd1;
        end else begin
          state_d = DROP;
        end
      end
      FRAME: begin
        if (!rx_dv) begin
          state_d = CHECK;
        end else begin
          if (idx_q != 11'h7FF) idx_d = idx_q + 11'd1;
          crc_d = crc_byte(crc_q, rx_data);
          if (rx_er) er_d = 1'b1;
          // Flags start set at SFD and clear on the first mismatching byte
          if (idx_q < 11'd6) begin
            if (rx_data != mac_byte) ucast_d = 1'b0;
            if (rx_data != 8'hFF)    bcast_d = 1'b0;
          end
          case (idx_q)
            11'd12: if (rx_data != 8'h08)          type_d  = 1'b0;
            11'd13: if (rx_data != 8'h00)          type_d  = 1'b0;
            11'd14: if (rx_data != 8'h45)          ver_d   = 1'b0;
            11'd23: if (rx_data != 8'h11)          proto_d = 1'b0;
            11'd36: if (rx_data != CMD_PORT[15:8]) port_d  = 1'b0;
            11'd37: if (rx_data != CMD_PORT[7:0])  port_d  = 1'b0;
            11'd42: code_sh_d = rx_data;
            11'd43, 11'd44, 11'd45, 11'd46: arg_sh_d = {arg_sh_q[23:0], rx_data};
            default: ;
          endcase
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (frame_err) begin
          if (frame_err_cnt_q != 16'hFFFF) frame_err_cnt_d = frame_err_cnt_q + 16'd1;
        end else if (hdr_match) begin
          cmd_valid_d = 1'b1;
          cmd_code_d  = code_sh_q;
          cmd_arg_d   = arg_sh_q;
          if (frame_ok_cnt_q != 16'hFFFF) frame_ok_cnt_d = frame_ok_cnt_q + 16'd1;
        end
      end
      DROP: begin
        if (!rx_dv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // dv_prev resets high so a frame already in flight at reset release is ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      dv_prev_q       <= 1'b1;
      pre_cnt_q       <= '0;
      idx_q           <= '0;
      crc_q           <= c_crc_init;
      er_q            <= 1'b0;
      ucast_q         <= 1'b0;
      bcast_q         <= 1'b0;
      type_q          <= 1'b0;
      ver_q           <= 1'b0;
      proto_q         <= 1'b0;
      port_q          <= 1'b0;
      code_sh_q       <= '0;
      arg_sh_q        <= '0;
      cmd_valid_q     <= 1'b0;
      cmd_code_q      <= '0;
      cmd_arg_q       <= '0;
      frame_ok_cnt_q  <= '0;
      frame_err_cnt_q <= '0;
    end else begin
      state_q         <= state_d;
      dv_prev_q       <= dv_prev_d;
      pre_cnt_q       <= pre_cnt_d;
      idx_q           <= idx_d;
      crc_q           <= crc_d;
      er_q            <= er_d;
      ucast_q         <= ucast_d;
      bcast_q         <= bcast_d;
      type_q          <= type_d;
      ver_q           <= ver_d;
      proto_q         <= proto_d;
      port_q          <= port_d;
      code_sh_q       <= code_sh_d;
      arg_sh_q        <= arg_sh_d;
      cmd_valid_q     <= cmd_valid_d;
      cmd_code_q      <= cmd_code_d;
      cmd_arg_q       <= cmd_arg_d;
      frame_ok_cnt_q  <= frame_ok_cnt_d;
      frame_err_cnt_q <= frame_err_cnt_d;
    end
  end

  assign cmd_valid     = cmd_valid_q;
  assign cmd_code      = cmd_code_q;
  assign cmd_arg       = cmd_arg_q;
  assign frame_ok_cnt  = frame_ok_cnt_q;
  assign frame_err_cnt = frame_err_cnt_q;
  assign busy          = (state_q != IDLE);

endmodule
`default_nettype wire

// File: doc/udp_cmd_rx.md
UDP_CMD_RX -- requirements
Module: udp_cmd_rx

Interface
REQ-001 Parameter LOCAL_MAC, default 48'h000A35000001, is the unicast destination MAC accepted.
REQ-002 Parameter CMD_PORT, default 16'h1234, is the UDP destination port accepted.
REQ-003 Port clk  input  1  125 MHz receive byte clock; all logic SHALL be on its rising edge.
REQ-004 Port rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 Port rx_dv  input  1  receive data valid, high for the whole frame including preamble.
REQ-006 Port rx_er  input  1  receive error, qualified by rx_dv.
REQ-007 Port rx_data  input  8  receive byte, LSB first on the wire.
REQ-008 Port cmd_valid  output  1  single-cycle pulse; accepted command present.
REQ-009 Port cmd_code  output  8  command code; valid while cmd_valid is high, held until the next accepted command.
REQ-010 Port cmd_arg  output  32  command argument, big-endian from payload; same validity rule as cmd_code.
REQ-011 Port frame_ok_cnt  output  16  count of accepted commands, saturating.
REQ-012 Port frame_err_cnt  output  16  count of errored frames, saturating.
REQ-013 Port busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, PREAMBLE, FRAME, CHECK and DROP.
REQ-015 IDLE SHALL move to PREAMBLE only on a rising edge of rx_dv (low then high) with rx_data=0x55; a rising edge with any other byte SHALL go to DROP.
REQ-016 PREAMBLE SHALL accept 0x55 bytes (7 total max) and move to FRAME on 0xD5; any other byte, or an 8th 0x55, SHALL go to DROP.
REQ-017 rx_dv falling in PREAMBLE or DROP SHALL return to IDLE with no counter change.
REQ-018 In FRAME, each rx_dv-high byte SHALL increment an 11-bit byte index (0 = first destination-MAC byte), saturating at 2047.
REQ-019 In FRAME, the block SHALL run the reflected CRC-32 (polynomial 0xEDB88320, init 0xFFFFFFFF, 8 bits per clock) over every byte, FCS included.
REQ-020 Header checks, latched as match flags: bytes 0-5 = LOCAL_MAC or FF:FF:FF:FF:FF:FF; bytes 12-13 = 0x0800; byte 14 = 0x45; byte 23 = 0x11; bytes 36-37 = CMD_PORT.
REQ-021 Payload capture: byte 42 SHALL go to a shadow code register, and bytes 43-46 to a shadow argument register, MSB first.
REQ-022 rx_dv falling in FRAME SHALL move to CHECK, which SHALL last exactly one cycle and then return to IDLE.
REQ-023 The frame SHALL be errored if any one of these holds: rx_er was seen high with rx_dv in FRAME; the final CRC register ≠ 0xDEBB20E3; the byte count < 64; the byte count > 1522.
REQ-024 In CHECK, an errored frame SHALL increment frame_err_cnt.
REQ-025 In CHECK, a non-errored frame with all match flags set SHALL drive cmd_valid for that one cycle, load cmd_code/cmd_arg from the shadow registers in the same cycle, and increment frame_ok_cnt.
REQ-026 In CHECK, a non-errored frame with any match flag clear SHALL be dropped silently, with no counter change.
REQ-027 Latency: cmd_valid SHALL assert on the first rising edge after the edge that samples rx_dv low.
REQ-028 Both counters SHALL hold at 0xFFFF and not wrap.
REQ-029 A new frame starting (rx_dv rising) in the cycle CHECK is active SHALL be ignored: rx_dv must be sampled low in IDLE first.

Reset
REQ-030 rst SHALL asynchronously force: IDLE; cmd_valid=0; cmd_code=0; cmd_arg=0; both counters=0; CRC=0xFFFFFFFF; all match flags clear; busy=0.
REQ-031 rst SHALL set the registered previous-rx_dv bit to 1, so a frame in progress when reset releases is ignored until rx_dv goes low.
REQ-032 rst asserted mid-frame SHALL discard that frame with no cmd_valid and no counter change.

Verification
REQ-033 Valid frame, dst LOCAL_MAC, port 0x1234, payload 01 DE AD BE EF, correct FCS -> one cmd_valid pulse, cmd_code=0x01, cmd_arg=0xDEADBEEF, frame_ok_cnt=1, frame_err_cnt=0.
REQ-034 Same frame with one FCS bit flipped -> no cmd_valid, frame_err_cnt=1; the same frame with rx_er high for one byte -> frame_err_cnt=2.
REQ-035 Good-CRC frames with port 0x1235, with ethertype 0x0806, and with a foreign MAC, back to back with 12-cycle gaps -> no cmd_valid, both counters unchanged; broadcast dst with port 0x1234 -> accepted.
REQ-036 60-byte frame (no FCS) and 1600-byte frame, both good CRC -> frame_err_cnt increments for each; preamble byte 0x54 -> DROP, no counter change.
REQ-037 Reset asserted at byte 30 of a valid frame and released at byte 40 -> no cmd_valid for that frame; the next valid frame is accepted normally.
REQ-038 Force frame_err_cnt to 0xFFFF via 65535 bad frames (or a backdoor write) then one more bad frame -> frame_err_cnt stays 0xFFFF.
